// File: rtl/fetch_decode_ctrl.sv
// fetch_decode_ctrl
// Sequences one instruction at a time through fetch, decode issue and execute.
// A request is issued at pc. The returned word is latched into the instruction
// register (IR), and imm_src is decoded from it when it is latched. The IR is
// then offered to execute, and the controller waits for ex_done before it moves
// pc and counts the retirement.
//
// Build option: define ILLEGAL_TRAP_EN to make an unsupported opcode stop the
// core with illegal=1 and halt=1. When it is undefined, an unsupported opcode
// is issued with imm_src=2'b11 and illegal is tied low.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   ifu_req_valid/addr    fetch request, address is the current pc
//   ifu_req_ready         memory accepts the request
//   ifu_rsp_valid/inst    instruction word return
//   dec_valid/ready       IR offered to execute / accepted
//   dec_inst, dec_pc      IR and its pc
//   imm_src               immediate format: 00 I, 01 U, 10 J, 11 other
//   ex_done, ex_redirect  execute finished; optionally redirect to ex_target
//   retire_cnt            retired-instruction count (wraps)
//   halt, illegal         sticky stop after ebreak / unsupported opcode
module fetch_decode_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req_valid,
    output logic [31:0] ifu_req_addr,
    input  logic        ifu_req_ready,
    input  logic        ifu_rsp_valid,
    input  logic [31:0] ifu_rsp_inst,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    output logic [1:0]  imm_src,
    input  logic        ex_done,
    input  logic        ex_redirect,
    input  logic [31:0] ex_target,
    output logic [31:0] retire_cnt,
    output logic        halt,
    output logic        illegal
);

    // state   | meaning
    // S_REQ   | fetch request presented at pc
    // S_WAIT  | request accepted, waiting for the instruction word
    // S_ISSUE | IR offered to execute
    // S_EXEC  | execute busy, waiting for ex_done
    // S_HALT  | stopped after ebreak (or trap); only reset leaves
    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_ISSUE,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [1:0]  imm_q;
    logic        halt_q;
    logic        capture;
    logic        is_ebreak;
    logic        retire;

    function automatic logic [1:0] imm_decode(input logic [6:0] op);
        case (op)
            7'b0010011, 7'b0000011, 7'b1100111: imm_decode = 2'b00;
            7'b0110111, 7'b0010111:             imm_decode = 2'b01;
            7'b1101111:                         imm_decode = 2'b10;
            default:                            imm_decode = 2'b11;
        endcase
    endfunction

    assign capture   = (state == S_WAIT) && ifu_rsp_valid;
    assign is_ebreak = (ifu_rsp_inst == EBREAK_INST);
    assign retire    = (state == S_EXEC) && ex_done;

`ifdef ILLEGAL_TRAP_EN
    // Only the opcodes with a known immediate format are executable. Every
    // other SYSTEM-opcode word is included, because ebreak is matched first.
    logic unsupported;
    logic illegal_q;
    assign unsupported = (imm_decode(ifu_rsp_inst[6:0]) == 2'b11);
    assign illegal     = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_REQ;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        ifu_req_valid = 1'b0;
        dec_valid     = 1'b0;
        case (state)
            S_REQ: begin
                ifu_req_valid = 1'b1;
                if (ifu_req_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (ifu_rsp_valid) begin
                    if (is_ebreak) state_nxt = S_HALT;
`ifdef ILLEGAL_TRAP_EN
                    else if (unsupported) state_nxt = S_HALT;
`endif
                    else state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                dec_valid = 1'b1;
                if (dec_ready) state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (ex_done) state_nxt = S_REQ;
            end
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_REQ;
        endcase
        // The state register already sits in S_REQ while reset is held, so the
        // handshake outputs are masked explicitly until reset is released.
        if (rst) begin
            ifu_req_valid = 1'b0;
            dec_valid     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            ir         <= 32'd0;
            imm_q      <= 2'b00;
            retire_cnt <= 32'd0;
            halt_q     <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q  <= 1'b0;
`endif
        end else begin
            if (capture) begin
                ir    <= ifu_rsp_inst;
                imm_q <= imm_decode(ifu_rsp_inst[6:0]);
                if (is_ebreak) halt_q <= 1'b1;
`ifdef ILLEGAL_TRAP_EN
                else if (unsupported) begin
                    halt_q    <= 1'b1;
                    illegal_q <= 1'b1;
                end
`endif
            end
            if (retire) begin
                pc         <= ex_redirect ? (ex_target & ~32'h3) : pc + 32'd4;
                retire_cnt <= retire_cnt + 32'd1;
            end
        end
    end

    assign ifu_req_addr = pc;
    assign dec_inst     = ir;
    assign dec_pc       = pc;
    assign imm_src      = imm_q;
    assign halt         = halt_q;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
module tb_fetch_decode_ctrl;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_req_valid;
    logic [31:0] ifu_req_addr;
    logic        ifu_req_ready = 1'b0;
    logic        ifu_rsp_valid = 1'b0;
    logic [31:0] ifu_rsp_inst  = 32'd0;
    logic        dec_valid;
    logic        dec_ready     = 1'b0;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic [1:0]  imm_src;
    logic        ex_done       = 1'b0;
    logic        ex_redirect   = 1'b0;
    logic [31:0] ex_target     = 32'd0;
    logic [31:0] retire_cnt;
    logic        halt;
    logic        illegal;

    fetch_decode_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr),
        .ifu_req_ready(ifu_req_ready),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_inst(ifu_rsp_inst),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_inst(dec_inst), .dec_pc(dec_pc), .imm_src(imm_src),
        .ex_done(ex_done), .ex_redirect(ex_redirect), .ex_target(ex_target),
        .retire_cnt(retire_cnt), .halt(halt), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] ret; } req_exp_t;
    typedef struct { logic [31:0] inst; logic [31:0] pc; logic [1:0] imm; } dec_exp_t;

    req_exp_t req_q[$];
    dec_exp_t dec_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_pc  = RESET_PC;
    logic [31:0] m_ret = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops an expectation at every handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (ifu_req_valid && ifu_req_ready) begin
                if (req_q.size() == 0) begin
                    chk("req_unexpected", ifu_req_addr, 32'hxxxx_xxxx);
                end else begin
                    req_exp_t e;
                    e = req_q.pop_front();
                    chk("req_addr", ifu_req_addr, e.addr);
                    chk("req_retire_cnt", retire_cnt, e.ret);
                end
            end
            if (dec_valid && dec_ready) begin
                if (dec_q.size() == 0) begin
                    chk("dec_unexpected", dec_inst, 32'hxxxx_xxxx);
                end else begin
                    dec_exp_t d;
                    d = dec_q.pop_front();
                    chk("dec_inst", dec_inst, d.inst);
                    chk("dec_pc", dec_pc, d.pc);
                    chk("dec_imm_src", {30'd0, imm_src}, {30'd0, d.imm});
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        ifu_req_ready = 0; ifu_rsp_valid = 0; dec_ready = 0; ex_done = 0; ex_redirect = 0;
        m_pc = RESET_PC; m_ret = 0;
        req_q.push_back('{RESET_PC, 32'd0});
        @(negedge clk);
        chk("rst_req_valid", {31'd0, ifu_req_valid}, 32'd0);
        chk("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
        chk("rst_retire", retire_cnt, 32'd0);
        chk("rst_halt", {31'd0, halt}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_ir", dec_inst, 32'd0);
        chk("rst_imm", {30'd0, imm_src}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_valid", {31'd0, ifu_req_valid}, 32'd1);
        chk("post_rst_addr", ifu_req_addr, RESET_PC);
        @(posedge clk); #1;
    endtask

    // Entered and left at posedge+1. spur drives a junk response during the
    // request phase, which must not be captured.
    task automatic fetch(input logic [31:0] inst, input int dly, input logic [1:0] imm,
                         input bit exp_dec, input bit spur);
        int n;
        if (exp_dec) dec_q.push_back('{inst, m_pc, imm});
        ifu_req_ready = 1'b1;
        if (spur) begin ifu_rsp_valid = 1'b1; ifu_rsp_inst = EBREAK; end
        n = 0;
        forever begin
            @(negedge clk);
            if (ifu_req_valid) break;
            n++;
            if (n > 50) begin chk("req_timeout", 32'd0, 32'd1); break; end
        end
        @(posedge clk); #1;
        ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_inst = 32'd0;
        @(negedge clk);
        chk("wait_req_valid", {31'd0, ifu_req_valid}, 32'd0);
        repeat (dly) @(posedge clk);
        #1;
        ifu_rsp_valid = 1'b1; ifu_rsp_inst = inst;
        @(posedge clk); #1;
        ifu_rsp_valid = 1'b0; ifu_rsp_inst = 32'd0;
        @(negedge clk);
        if (exp_dec) begin
            chk("dec_latency", {31'd0, dec_valid}, 32'd1);
        end else begin
            chk("halt_set", {31'd0, halt}, 32'd1);
            chk("halt_dec_valid", {31'd0, dec_valid}, 32'd0);
        end
        @(posedge clk); #1;
    endtask

    task automatic issue(input int hold, input logic [31:0] inst, input logic [1:0] imm);
        int n;
        dec_ready = 1'b0;
        if (hold > 0) begin
            ex_done = 1'b1; ifu_rsp_valid = 1'b1; ifu_rsp_inst = EBREAK;
        end
        repeat (hold) begin
            @(negedge clk);
            chk("hold_dec_valid", {31'd0, dec_valid}, 32'd1);
            chk("hold_dec_inst", dec_inst, inst);
            chk("hold_imm_src", {30'd0, imm_src}, {30'd0, imm});
            @(posedge clk); #1;
        end
        ex_done = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_inst = 32'd0;
        dec_ready = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (dec_valid) break;
            n++;
            if (n > 50) begin chk("dec_timeout", 32'd0, 32'd1); break; end
        end
        @(posedge clk); #1;
        dec_ready = 1'b0;
    endtask

    task automatic execute(input bit redir, input logic [31:0] target, input int dly);
        repeat (dly) @(posedge clk);
        #1;
        ex_done = 1'b1; ex_redirect = redir; ex_target = target;
        m_pc  = redir ? {target[31:2], 2'b00} : m_pc + 32'd4;
        m_ret = m_ret + 32'd1;
        req_q.push_back('{m_pc, m_ret});
        @(posedge clk); #1;
        ex_done = 1'b0; ex_redirect = 1'b0; ex_target = 32'd0;
        @(negedge clk);
        chk("exec_req_latency", {31'd0, ifu_req_valid}, 32'd1);
        chk("exec_next_addr", ifu_req_addr, m_pc);
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        do_reset();

        // addi, 3-cycle response delay, junk response during the request phase
        fetch(32'h0010_0093, 3, 2'b00, 1, 1);
        issue(0, 32'h0010_0093, 2'b00);
        execute(0, 32'd0, 1);
        chk("addi_next_pc", m_pc, 32'h8000_0004);

        // jal with misaligned redirect target, dec_ready stalled 5 cycles
        fetch(32'h0080_006F, 1, 2'b10, 1, 0);
        issue(5, 32'h0080_006F, 2'b10);
        execute(1, 32'h8000_0013, 2);

        // lui
        fetch(32'h1234_5037, 2, 2'b01, 1, 0);
        issue(1, 32'h1234_5037, 2'b01);
        execute(0, 32'd0, 0);

        // opcode 7'b1111111
`ifdef ILLEGAL_TRAP_EN
        fetch(32'h0000_007F, 1, 2'b11, 0, 0);
        chk("trap_illegal", {31'd0, illegal}, 32'd1);
        do_reset();
`else
        fetch(32'h0000_007F, 1, 2'b11, 1, 0);
        chk("no_trap_illegal", {31'd0, illegal}, 32'd0);
        issue(0, 32'h0000_007F, 2'b11);
        execute(0, 32'd0, 0);
        chk("retire_after_four", m_ret, 32'd4);
`endif

        // ebreak: halt, no further requests while memory stays ready
        fetch(EBREAK, 2, 2'b11, 0, 0);
        ifu_req_ready = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (ifu_req_valid) cnt++;
        end
        @(posedge clk); #1;
        ifu_req_ready = 1'b0;
        chk("halt_no_req", cnt, 0);
        chk("halt_retire", retire_cnt, m_ret);
        chk("halt_sticky", {31'd0, halt}, 32'd1);

        do_reset();
        chk("restart_halt", {31'd0, halt}, 32'd0);

        // reset in S_WAIT, then a late response while back in S_REQ
        ifu_req_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        ifu_req_ready = 1'b0;
        do_reset();
        ifu_rsp_valid = 1'b1; ifu_rsp_inst = EBREAK;
        repeat (2) begin
            @(negedge clk);
            chk("late_rsp_halt", {31'd0, halt}, 32'd0);
            chk("late_rsp_req_valid", {31'd0, ifu_req_valid}, 32'd1);
            @(posedge clk); #1;
        end
        ifu_rsp_valid = 1'b0; ifu_rsp_inst = 32'd0;

        // pc wrap: redirect to top word, then pc+4 wraps to zero
        fetch(32'h0010_0093, 1, 2'b00, 1, 0);
        issue(0, 32'h0010_0093, 2'b00);
        execute(1, 32'hFFFF_FFFF, 0);
        fetch(32'h0000_0017, 1, 2'b01, 1, 0);
        issue(0, 32'h0000_0017, 2'b01);
        execute(0, 32'd0, 0);
        chk("wrap_pc", m_pc, 32'h0000_0000);

        // let the final request handshake so the monitor checks it
        ifu_req_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        ifu_req_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("req_queue_drained", req_q.size(), 0);
        chk("dec_queue_drained", dec_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
